// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit holding the HI/LO pair.
//
// It runs one shift-add step (multiply) or one restoring-subtract step
// (divide) per clock. A sign fix-up cycle follows, and then HI/LO are written.
//
// Ports:
//   CLK        clock; all state changes on posedge
//   RST        synchronous active-low reset
//   START      begin an op (sampled in IDLE only)
//   OP         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SRCA/SRCB  multiplicand/multiplier or dividend/divisor
//   FLUSH      abort the in-flight op; drops a START in the same IDLE cycle
//   WE_HI/LO   MTHI/MTLO write enables (honoured in IDLE only)
//   WD         MTHI/MTLO write data
//   BUSY       high whenever the FSM is not IDLE
//   DONE       one-cycle pulse; HI/LO were just updated
//   HI/LO      architectural HI/LO registers
//   DBG_STATE  current FSM state (IDLE=0, RUN=1, FIX=2)
//
// Handshake: START is a level request accepted on any IDLE edge where
// FLUSH=0. While BUSY=1 the unit ignores START, WE_HI and WE_LO. DONE marks
// the only cycle in which a completed result has just landed in HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] SRCA,
    input  logic [WIDTH-1:0] SRCB,
    input  logic             FLUSH,
    input  logic             WE_HI,
    input  logic             WE_LO,
    input  logic [WIDTH-1:0] WD,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       DBG_STATE
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNTW-1:0]  cnt;
    logic [1:0]       op_q;
    logic             sign_q;
    logic             sign_r;
    logic             div_zero;
    logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    // Operand magnitudes for the op being requested.
    logic             in_signed;
    logic             in_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        in_signed = ~OP[0];
        in_div    = OP[1];
        a_mag     = (in_signed && SRCA[WIDTH-1]) ? -SRCA : SRCA;
        b_mag     = (in_signed && SRCB[WIDTH-1]) ? -SRCB : SRCB;
    end

    // One iteration step.
    logic             is_signed;
    logic             is_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        is_signed = ~op_q[0];
        is_div    = op_q[1];
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
        div_sh    = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, opb};
        // The remainder stays below the divisor, so the difference always fits in WIDTH bits.
        div_sub   = div_sh[WIDTH-1:0] - opb;
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied in FIX.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (is_signed && sign_q) ? -prod : prod;
        if (is_div) begin
            // On divide-by-zero the all-ones quotient is reported unsigned.
            fix_lo = (is_signed && sign_q && !div_zero) ? -acc_lo : acc_lo;
            fix_hi = (is_signed && sign_r) ? -acc_hi : acc_hi;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (WE_HI) hi_q <= WD;
                    if (WE_LO) lo_q <= WD;
                    if (START && !FLUSH) begin
                        state    <= RUN;
                        cnt      <= '0;
                        op_q     <= OP;
                        sign_q   <= SRCA[WIDTH-1] ^ SRCB[WIDTH-1];
                        sign_r   <= SRCA[WIDTH-1];
                        div_zero <= (SRCB == '0);
                        acc_hi   <= '0;
                        acc_lo   <= in_div ? a_mag : b_mag;
                        opb      <= in_div ? b_mag : a_mag;
                    end
                end
                RUN: begin
                    if (FLUSH) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + CNTW'(1);
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!FLUSH) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign BUSY      = (state != IDLE);
    assign DONE      = done_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [1:0]  OP;
    logic [31:0] SRCA;
    logic [31:0] SRCB;
    logic        FLUSH;
    logic        WE_HI;
    logic        WE_LO;
    logic [31:0] WD;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [1:0]  DBG_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(32), .CNTW(5)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .SRCA(SRCA), .SRCB(SRCB),
        .FLUSH(FLUSH), .WE_HI(WE_HI), .WE_LO(WE_LO), .WD(WD),
        .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO), .DBG_STATE(DBG_STATE)
    );

    // Clock and watchdog.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver helpers. Inputs change #1 after the edge, and outputs are sampled there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        RST = 1'b1;
    endtask

    // Full op with latency and BUSY-width checks.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int busy_n;
        OP = op; SRCA = a; SRCB = b; START = 1'b1;
        tick();
        START = 1'b0;
        lat = 0;
        busy_n = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY === 1'b1) busy_n++;
            tick();
            lat++;
        end
        check({name, " latency"}, lat, 33);
        check({name, " busy cycles"}, busy_n, 33);
        check({name, " busy at done"}, BUSY, 0);
        check({name, " HI"}, HI, exp_hi);
        check({name, " LO"}, LO, exp_lo);
        tick();
        check({name, " done one cycle"}, DONE, 0);
    endtask

    // Counts DONE pulses over a window; used after aborted ops.
    task automatic count_done(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (DONE === 1'b1) dones++;
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int dones;
        int first;
        int lat;

        vecs[0]  = '{"multu max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult -3x5",     OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"div -7/2",      OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu by 0",     OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[4]  = '{"div min/-1",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu 100/7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{"div 7/-2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{"mult min*min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{"multu 7x6",     OP_MULTU, 32'd7,        32'd6,        32'd0,        32'd42};
        vecs[9]  = '{"div -5 by 0",   OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[10] = '{"mult max*-1",   OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[11] = '{"divu max/16",   OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[12] = '{"multu 2^16sq",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        RST = 1'b0; START = 1'b0; OP = 2'b00; SRCA = '0; SRCB = '0;
        FLUSH = 1'b0; WE_HI = 1'b0; WE_LO = 1'b0; WD = '0;

        // Reset state.
        tick();
        tick();
        check("reset busy", BUSY, 0);
        check("reset done", DONE, 0);
        check("reset HI", HI, 0);
        check("reset LO", LO, 0);
        check("reset state", DBG_STATE, 0);
        RST = 1'b1;

        // Table-driven ops.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // FLUSH at iteration 10.
        do_reset();
        OP = OP_MULTU; SRCA = 32'd7; SRCB = 32'd6; START = 1'b1;
        tick();
        START = 1'b0;
        check("flush run state", DBG_STATE, 1);
        repeat (10) tick();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("flush busy", BUSY, 0);
        check("flush done", DONE, 0);
        check("flush HI", HI, 0);
        check("flush LO", LO, 0);
        count_done(40, dones);
        check("flush no done", dones, 0);
        check("flush LO later", LO, 0);

        // Reset at iteration 20.
        OP = OP_MULTU; SRCA = 32'd7; SRCB = 32'd6; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (20) tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("midreset busy", BUSY, 0);
        check("midreset HI", HI, 0);
        check("midreset LO", LO, 0);
        count_done(40, dones);
        check("midreset no done", dones, 0);
        check("midreset LO later", LO, 0);

        // Second START while busy is ignored.
        OP = OP_MULTU; SRCA = 32'd7; SRCB = 32'd6; START = 1'b1;
        tick();
        START = 1'b0;
        dones = 0;
        first = -1;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                START = 1'b1; OP = OP_DIVU; SRCA = 32'd100; SRCB = 32'd7;
            end
            if (i == 6) START = 1'b0;
            tick();
            if (DONE === 1'b1) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        check("restart done count", dones, 1);
        check("restart done edge", first, 33);
        check("restart HI", HI, 0);
        check("restart LO", LO, 42);

        // MTHI in IDLE.
        WE_HI = 1'b1; WD = 32'hAAAA5555;
        tick();
        WE_HI = 1'b0;
        check("mthi HI", HI, 32'hAAAA5555);
        check("mthi LO kept", LO, 42);

        // MTLO while busy is ignored.
        OP = OP_DIVU; SRCA = 32'd100; SRCB = 32'd7; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        WE_LO = 1'b1; WD = 32'h1;
        tick();
        WE_LO = 1'b0;
        check("mtlo busy LO", LO, 42);
        check("mtlo busy HI", HI, 32'hAAAA5555);
        lat = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("mtlo busy done seen", DONE, 1);
        check("mtlo busy final LO", LO, 14);
        check("mtlo busy final HI", HI, 2);

        // MTLO together with START: write lands, then the result overwrites it.
        WE_LO = 1'b1; WD = 32'h55; OP = OP_MULTU; SRCA = 32'd3; SRCB = 32'd3; START = 1'b1;
        tick();
        WE_LO = 1'b0; START = 1'b0;
        check("mtlo+start LO", LO, 32'h55);
        check("mtlo+start busy", BUSY, 1);
        repeat (32) tick();
        check("mtlo+start fix state", DBG_STATE, 2);
        check("mtlo+start LO in fix", LO, 32'h55);
        tick();
        check("mtlo+start done", DONE, 1);
        check("mtlo+start final LO", LO, 9);
        check("mtlo+start final HI", HI, 0);

        // START with FLUSH in IDLE is dropped.
        OP = OP_MULTU; SRCA = 32'd5; SRCB = 32'd5; START = 1'b1; FLUSH = 1'b1;
        tick();
        START = 1'b0; FLUSH = 1'b0;
        check("start+flush busy", BUSY, 0);
        check("start+flush state", DBG_STATE, 0);
        count_done(40, dones);
        check("start+flush no done", dones, 0);
        check("start+flush LO", LO, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
